data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/types_pkg.sv | 32 +++
 rtl/mem_arb_pick.sv | 33 +++
 rtl/data_mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_data_mem_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// Shared types for the data memory arbiter.
// Build option: DATA_MEM_ARB_CORE_PRIORITY_EN selects fixed core priority
// with a DMA starvation override instead of round-robin.
package types_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0]   DATA_BUS;
  typedef logic [XLEN/8-1:0] byte_format;

  // Ownership FSM: IDLE arbitrates normally, OWN_D locks the memory to the DMA port
  typedef enum logic {IDLE = 1'b0, OWN_D = 1'b1} own_state_e;

  // Port identifier, used for the last-winner bit and response routing
  typedef enum logic {PORT_C = 1'b0, PORT_D = 1'b1} port_id_e;

  // One memory access as it sits in the access stage
  typedef struct packed {
    logic       we;
    port_id_e   port;
    DATA_BUS    addr;
    DATA_BUS    wd;
    byte_format bsel;
  } acc_req_t;

`ifdef DATA_MEM_ARB_CORE_PRIORITY_EN
  localparam bit CORE_PRIO_EN = 1'b1;
`else
  localparam bit CORE_PRIO_EN = 1'b0;
`endif

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between core and DMA in the IDLE state.
// Round-robin by default; with DATA_MEM_ARB_CORE_PRIORITY_EN the core always
// wins a tie unless the starvation override is raised.
module mem_arb_pick
  import types_pkg::*;
(
  input  logic     c_req_i,
  input  logic     d_req_i,
  input  port_id_e last_i,
  input  logic     starve_i,
  output logic     c_win_o,
  output logic     d_win_o
);

  logic prefer_d;

  // On a tie, d wins if it is starved or (round-robin) the core won last time
  assign prefer_d = starve_i | (!CORE_PRIO_EN && (last_i == PORT_C));

  // A lone requester always wins; ties go to the preferred port
  always_comb begin
    c_win_o = 1'b0;
    d_win_o = 1'b0;
    if (c_req_i && d_req_i) begin
      d_win_o = prefer_d;
      c_win_o = !prefer_d;
    end else begin
      c_win_o = c_req_i;
      d_win_o = d_req_i;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port (core / DMA) arbiter in front of a single-port data memory.
// Grant in cycle N, memory access in N+1, read response in N+2.
// Build option: DATA_MEM_ARB_CORE_PRIORITY_EN adds core priority with a
// DMA starvation counter (STARVE_LIMIT losses force one DMA grant).
module data_mem_arbiter
  import types_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  // core port
  input  logic       c_req,
  input  logic       c_we,
  input  DATA_BUS    c_addr,
  input  DATA_BUS    c_wd,
  input  byte_format c_bsel,
  output logic       c_gnt,
  output logic       c_rvalid,
  output DATA_BUS    c_rd,
  // DMA / loader port
  input  logic       d_req,
  input  logic       d_we,
  input  logic       d_lock,
  input  DATA_BUS    d_addr,
  input  DATA_BUS    d_wd,
  input  byte_format d_bsel,
  output logic       d_gnt,
  output logic       d_rvalid,
  output DATA_BUS    d_rd,
  // memory
  output logic       mem_we,
  output DATA_BUS    mem_a,
  output DATA_BUS    mem_wd,
  output byte_format mem_bsel,
  input  DATA_BUS    mem_rd
);

  own_state_e state_q, state_d;
  port_id_e   last_q, last_d;
  logic       c_win, d_win, starve;
  logic       any_gnt;
  acc_req_t   acc_d, acc_q;
  logic       acc_vld_q;
  logic       rsp_vld_q;
  port_id_e   rsp_port_q;
  DATA_BUS    rsp_data_q;

`ifdef DATA_MEM_ARB_CORE_PRIORITY_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_q;

  assign starve = (starve_q == SW'(STARVE_LIMIT));

  // Count DMA losses; any DMA grant (forced or not) restarts the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        starve_q <= '0;
    else if (d_gnt)                 starve_q <= '0;
    else if (d_req && !starve)      starve_q <= starve_q + SW'(1);
  end
`else
  // Limit only matters under core priority; round-robin never starves
  assign starve = (STARVE_LIMIT < 0);
`endif

  mem_arb_pick u_pick (
    .c_req_i  (c_req),
    .d_req_i  (d_req),
    .last_i   (last_q),
    .starve_i (starve),
    .c_win_o  (c_win),
    .d_win_o  (d_win)
  );

  // Ownership state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Enter OWN_D on a locked DMA grant, leave on the first cycle lock drops
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (d_gnt && d_lock) state_d = OWN_D;
      OWN_D:   if (!d_lock)         state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grants: OWN_D serves only d; nothing is granted while reset is held
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      if (state_q == OWN_D) begin
        d_gnt = d_req;
      end else begin
        c_gnt = c_win;
        d_gnt = d_win;
      end
    end
  end

  assign any_gnt = c_gnt | d_gnt;
  assign last_d  = c_gnt ? PORT_C : (d_gnt ? PORT_D : last_q);

  // Last winner starts at d so the core takes the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= PORT_D;
    else     last_q <= last_d;
  end

  // Select the granted port's request for the access stage
  always_comb begin
    acc_d = '{we: c_we, port: PORT_C, addr: c_addr, wd: c_wd, bsel: c_bsel};
    if (d_gnt) acc_d = '{we: d_we, port: PORT_D, addr: d_addr, wd: d_wd, bsel: d_bsel};
  end

  // Access stage; payload only loads on a grant so the memory bus holds when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_vld_q <= 1'b0;
      acc_q     <= '0;
    end else begin
      acc_vld_q <= any_gnt;
      if (any_gnt) acc_q <= acc_d;
    end
  end

  assign mem_we   = acc_vld_q & acc_q.we;
  assign mem_a    = acc_q.addr;
  assign mem_wd   = acc_q.wd;
  assign mem_bsel = acc_q.bsel;

  // Response stage: capture read data and remember which port asked
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_vld_q  <= 1'b0;
      rsp_port_q <= PORT_C;
      rsp_data_q <= '0;
    end else begin
      rsp_vld_q <= acc_vld_q & !acc_q.we;
      if (acc_vld_q && !acc_q.we) begin
        rsp_port_q <= acc_q.port;
        rsp_data_q <= mem_rd;
      end
    end
  end

  assign c_rvalid = rsp_vld_q && (rsp_port_q == PORT_C);
  assign d_rvalid = rsp_vld_q && (rsp_port_q == PORT_D);
  assign c_rd     = rsp_data_q;
  assign d_rd     = rsp_data_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: a table of per-cycle arbitration
// vectors plus hand sequences for latency, read-after-write, DMA lock,
// reset mid-write and (with DATA_MEM_ARB_CORE_PRIORITY_EN) starvation.
module tb_data_mem_arbiter;
  import types_pkg::*;

`ifdef DATA_MEM_ARB_CORE_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       c_req, c_we, d_req, d_we, d_lock;
  DATA_BUS    c_addr, c_wd, d_addr, d_wd;
  byte_format c_bsel, d_bsel;
  logic       c_gnt, c_rvalid, d_gnt, d_rvalid, mem_we;
  DATA_BUS    c_rd, d_rd, mem_a, mem_wd, mem_rd;
  byte_format mem_bsel;

  int n_chk  = 0;
  int n_fail = 0;

  data_mem_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wd(c_wd), .c_bsel(c_bsel),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rd(c_rd),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wd(d_wd),
    .d_bsel(d_bsel), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rd(d_rd),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_bsel(mem_bsel),
    .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Memory model: filled on the first edge, then written only by the DUT
  logic [31:0] mem [0:255];
  logic        mem_init = 1'b0;

  function automatic logic [31:0] init_val(int a);
    return (a == 'h10) ? 32'hDEADBEEF : (32'hA000_0000 | a);
  endfunction

  assign mem_rd = mem[mem_a[7:0]];

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int a = 0; a < 256; a++) mem[a] <= init_val(a);
      mem_init <= 1'b1;
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_bsel[b]) mem[mem_a[7:0]][8*b +: 8] <= mem_wd[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    c_req = 0; c_we = 0; c_addr = '0; c_wd = '0; c_bsel = 4'hF;
    d_req = 0; d_we = 0; d_lock = 0; d_addr = '0; d_wd = '0; d_bsel = 4'hF;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic       c_req, d_req;
    logic [7:0] c_addr, d_addr;
    logic       c_rr, d_rr, c_pr, d_pr;  // expected grants: round-robin / core priority
  } vec_t;

  vec_t vt [12];

  initial begin
    logic ec [12];
    logic ed [12];
    int   dcount;

    // ---- reset state, with both ports requesting ----
    idle();
    c_req = 1; d_req = 1;
    #2;
    chk("rst_c_gnt", c_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_c_rvalid", c_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_c_rd", c_rd, 0);
    chk("rst_d_rd", d_rd, 0);
    chk("rst_mem_a", mem_a, 0);
    do_reset();

    // ---- table: per-cycle arbitration, all reads ----
    vt[0]  = '{1, 1, 8'h00, 8'h80, 1, 0, 1, 0};
    vt[1]  = '{1, 1, 8'h01, 8'h81, 0, 1, 1, 0};
    vt[2]  = '{1, 1, 8'h02, 8'h82, 1, 0, 1, 0};
    vt[3]  = '{1, 1, 8'h03, 8'h83, 0, 1, 1, 0};
    vt[4]  = '{0, 1, 8'h04, 8'h84, 0, 1, 0, 1};
    vt[5]  = '{1, 0, 8'h05, 8'h85, 1, 0, 1, 0};
    vt[6]  = '{0, 0, 8'h06, 8'h86, 0, 0, 0, 0};
    vt[7]  = '{1, 1, 8'h07, 8'h87, 0, 1, 1, 0};
    vt[8]  = '{0, 0, 8'h08, 8'h88, 0, 0, 0, 0};
    vt[9]  = '{1, 1, 8'h09, 8'h89, 1, 0, 1, 0};
    vt[10] = '{0, 0, 8'h0A, 8'h8A, 0, 0, 0, 0};
    vt[11] = '{0, 0, 8'h0B, 8'h8B, 0, 0, 0, 0};

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      c_req = vt[i].c_req; d_req = vt[i].d_req;
      c_addr = {24'h0, vt[i].c_addr}; d_addr = {24'h0, vt[i].d_addr};
      ec[i] = PRIO ? vt[i].c_pr : vt[i].c_rr;
      ed[i] = PRIO ? vt[i].d_pr : vt[i].d_rr;
      #1;
      chk($sformatf("tbl%0d_c_gnt", i), c_gnt, ec[i]);
      chk($sformatf("tbl%0d_d_gnt", i), d_gnt, ed[i]);
      if (i >= 2) begin
        chk($sformatf("tbl%0d_c_rvalid", i), c_rvalid, ec[i-2]);
        chk($sformatf("tbl%0d_d_rvalid", i), d_rvalid, ed[i-2]);
        if (ec[i-2]) chk($sformatf("tbl%0d_c_rd", i), c_rd, 32'hA000_0000 | vt[i-2].c_addr);
        if (ed[i-2]) chk($sformatf("tbl%0d_d_rd", i), d_rd, 32'hA000_0000 | vt[i-2].d_addr);
      end
    end

    // ---- core read latency: grant N, data N+2, nothing on d ----
    do_reset();
    @(negedge clk);
    c_req = 1; c_addr = 32'h10;
    #1;
    chk("rd_c_gnt_N", c_gnt, 1);
    chk("rd_d_gnt_N", d_gnt, 0);
    @(negedge clk);
    idle();
    #1;
    chk("rd_mem_a_N1", mem_a, 32'h10);
    chk("rd_mem_we_N1", mem_we, 0);
    chk("rd_c_rvalid_N1", c_rvalid, 0);
    @(negedge clk);
    #1;
    chk("rd_c_rvalid_N2", c_rvalid, 1);
    chk("rd_c_rd_N2", c_rd, 32'hDEADBEEF);
    chk("rd_d_rvalid_N2", d_rvalid, 0);
    chk("rd_mem_a_hold", mem_a, 32'h10);
    @(negedge clk);
    #1;
    chk("rd_c_rvalid_N3", c_rvalid, 0);

    // ---- read-after-write on consecutive grants ----
    do_reset();
    @(negedge clk);
    c_req = 1; c_we = 1; c_addr = 32'h30; c_wd = 32'hAA;
    @(negedge clk);
    c_we = 0; c_wd = '0;
    #1;
    chk("raw_mem_we_N1", mem_we, 1);
    chk("raw_mem_wd_N1", mem_wd, 32'hAA);
    @(negedge clk);
    idle();
    #1;
    chk("raw_no_wr_rvalid", c_rvalid, 0);
    chk("raw_mem_we_N2", mem_we, 0);
    @(negedge clk);
    #1;
    chk("raw_c_rvalid", c_rvalid, 1);
    chk("raw_c_rd", c_rd, 32'hAA);

    // ---- DMA lock: c shut out while d owns the memory ----
    do_reset();
    if (!PRIO) begin
      @(negedge clk);              // core wins the first tie-free cycle, last=c
      c_req = 1; c_addr = 32'h0;
      #1;
      chk("lk_setup_c_gnt", c_gnt, 1);
    end
    @(negedge clk);
    c_req = !PRIO; c_addr = 32'h0;
    d_req = 1; d_we = 1; d_lock = 1; d_addr = 32'h20; d_wd = 32'h1234;
    #1;
    chk("lk1_d_gnt", d_gnt, 1);
    chk("lk1_c_gnt", c_gnt, 0);
    @(negedge clk);
    c_req = 1; d_addr = 32'h21; d_wd = 32'h5678;
    #1;
    chk("lk2_d_gnt", d_gnt, 1);
    chk("lk2_c_gnt", c_gnt, 0);
    @(negedge clk);
    d_lock = 0; d_addr = 32'h22; d_wd = 32'h9ABC;   // releasing cycle still owned by d
    #1;
    chk("lk3_d_gnt", d_gnt, 1);
    chk("lk3_c_gnt", c_gnt, 0);
    @(negedge clk);
    d_req = 0; d_we = 0;
    #1;
    chk("lk4_c_gnt", c_gnt, 1);
    chk("lk4_d_gnt", d_gnt, 0);
    @(negedge clk);
    idle();
    repeat (2) @(negedge clk);
    chk("lk_mem20", mem[8'h20], 32'h1234);
    chk("lk_mem22", mem[8'h22], 32'h9ABC);

    // ---- reset while a write sits in the access stage ----
    do_reset();
    @(negedge clk);
    c_req = 1; c_we = 1; c_addr = 32'h40; c_wd = 32'h99;
    @(negedge clk);
    d_req = 1;
    #1;
    chk("rw_mem_we_before", mem_we, 1);
    rst = 1'b1;
    #1;
    chk("rw_mem_we_rst", mem_we, 0);
    chk("rw_c_gnt_rst", c_gnt, 0);
    chk("rw_d_gnt_rst", d_gnt, 0);
    chk("rw_c_rvalid", c_rvalid, 0);
    chk("rw_d_rvalid", d_rvalid, 0);
    chk("rw_mem_a_rst", mem_a, 0);
    @(negedge clk);
    chk("rw_mem40_unchanged", mem[8'h40], 32'hA000_0040);
    idle();
    rst = 1'b0;

`ifdef DATA_MEM_ARB_CORE_PRIORITY_EN
    // ---- starvation: d forced once every STARVE_LIMIT+1 grants ----
    do_reset();
    dcount = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      c_req = 1; d_req = 1; c_addr = 32'h1; d_addr = 32'h2;
      #1;
      chk($sformatf("stv%0d_d_gnt", i), d_gnt, (i % 9) == 8);
      chk($sformatf("stv%0d_c_gnt", i), c_gnt, (i % 9) != 8);
      if (d_gnt) dcount++;
    end
    chk("stv_d_count", dcount, 2);
    @(negedge clk);
    idle();
`else
    dcount = 0;
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
